// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end for the decode stage.
// It combines a PC generator with a DEPTH-entry prefetch FIFO. Each FIFO entry
// holds {instr, pc}. Decode takes entries from the head with a valid/ready
// handshake.
//
// Ports
//   clk, rst_n    rising-edge clock; asynchronous active-low reset
//   imem_addr     fetch address to instruction memory (always fetch_pc)
//   imem_rd       fetch enable this cycle
//   imem_data     instruction at imem_addr, combinational read
//   redirect      branch taken / flush request (highest priority)
//   redirect_pc   new fetch address, used when redirect is high
//   out_valid     head entry valid
//   out_ready     decode accepts the head entry
//   out_instr     head instruction
//   out_pc        head PC
//   out_pc_plus   head PC + INC
//   fetch_pc      current PC register
//   count         number of occupied entries
//   halted        halt opcode fetched; fetching stopped until redirect
module fetch_queue #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                INC      = 2,
  parameter logic [3:0]        HALT_OP  = 4'hF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [ADDR_W-1:0]          imem_addr,
  output logic                       imem_rd,
  input  logic [DATA_W-1:0]          imem_data,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [ADDR_W-1:0]          out_pc_plus,
  output logic [ADDR_W-1:0]          fetch_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       halted
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam int                CNT_W   = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0]  FULL    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
  localparam logic [ADDR_W-1:0] INC_A   = ADDR_W'(INC);

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop;
  logic              fetch_en;
  logic              is_halt;

  // Handshake and fetch decision (combinational)
  // A redirect hides the head, so a pop never coincides with a flush.
  assign out_valid = (count != '0) & ~redirect;
  assign pop       = out_valid & out_ready;
  // Gating with rst_n holds imem_rd low while reset is asserted, even
  // though count is already 0.
  assign fetch_en  = rst_n & ~redirect & ~halted & ((count < FULL) | pop);
  assign imem_rd   = fetch_en;
  assign imem_addr = fetch_pc;
  assign is_halt   = (imem_data[DATA_W-1 -: 4] == HALT_OP);

  // Control state: PC, pointers, occupancy, halt flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      halted   <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      halted   <= 1'b0;
    end else begin
      if (fetch_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        // A halt entry is still queued, but the PC stays parked on it.
        if (is_halt) halted   <= 1'b1;
        else         fetch_pc <= fetch_pc + INC_A;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({fetch_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (fetch_en) begin
      instr_mem[wr_ptr] <= imem_data;
      pc_mem[wr_ptr]    <= fetch_pc;
    end
  end

  // Head read-out (combinational)
  assign out_instr   = instr_mem[rd_ptr];
  assign out_pc      = pc_mem[rd_ptr];
  assign out_pc_plus = out_pc + INC_A;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue.
// The reference model is a queue of {pc, instr} entries plus a model PC and
// a halt flag.
module tb_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] out_pc_plus;
  logic [15:0] fetch_pc;
  logic [2:0]  count;
  logic        halted;

  fetch_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .imem_data  (imem_data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_pc_plus(out_pc_plus),
    .fetch_pc   (fetch_pc),
    .count      (count),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model
  logic [15:0] q_pc    [$];
  logic [15:0] q_instr [$];
  logic [15:0] m_pc;
  logic        m_halted;
  logic        e_valid, e_pop, e_fetch, cur_inj;
  logic [15:0] e_plus;

  task automatic model_reset();
    q_pc.delete();
    q_instr.delete();
    m_pc     = 16'h0000;
    m_halted = 1'b0;
  endtask

  // Apply one cycle of inputs (called in the low clock phase) and compare all
  // outputs against the model's view of the queue.
  task automatic drive(input logic rdy, input logic redir, input logic [15:0] rpc,
                       input logic inj);
    out_ready   = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    cur_inj     = inj;
    imem_data   = (inj ? 16'hF000 : 16'h1000) | (m_pc & 16'h0FFF);
    #1;
    e_valid = (q_pc.size() != 0) && !redir;
    e_pop   = e_valid && rdy;
    e_fetch = !redir && !m_halted && ((q_pc.size() < 4) || e_pop);
    total++; if (imem_rd !== e_fetch) begin bad++;
      $display("FAIL imem_rd t=%0t got=%b exp=%b", $time, imem_rd, e_fetch); end
    total++; if (fetch_pc !== m_pc) begin bad++;
      $display("FAIL fetch_pc t=%0t got=%h exp=%h", $time, fetch_pc, m_pc); end
    total++; if (imem_addr !== m_pc) begin bad++;
      $display("FAIL imem_addr t=%0t got=%h exp=%h", $time, imem_addr, m_pc); end
    total++; if (count !== 3'(q_pc.size())) begin bad++;
      $display("FAIL count t=%0t got=%0d exp=%0d", $time, count, q_pc.size()); end
    total++; if (out_valid !== e_valid) begin bad++;
      $display("FAIL out_valid t=%0t got=%b exp=%b", $time, out_valid, e_valid); end
    total++; if (halted !== m_halted) begin bad++;
      $display("FAIL halted t=%0t got=%b exp=%b", $time, halted, m_halted); end
    if (e_valid) begin
      e_plus = q_pc[0] + 16'd2;
      total++; if (out_pc !== q_pc[0]) begin bad++;
        $display("FAIL out_pc t=%0t got=%h exp=%h", $time, out_pc, q_pc[0]); end
      total++; if (out_instr !== q_instr[0]) begin bad++;
        $display("FAIL out_instr t=%0t got=%h exp=%h", $time, out_instr, q_instr[0]); end
      total++; if (out_pc_plus !== e_plus) begin bad++;
        $display("FAIL out_pc_plus t=%0t got=%h exp=%h", $time, out_pc_plus, e_plus); end
    end
  endtask

  // Take the clock edge, update the model, and return in the low phase.
  task automatic advance();
    @(posedge clk);
    if (redirect) begin
      q_pc.delete();
      q_instr.delete();
      m_pc     = redirect_pc;
      m_halted = 1'b0;
    end else begin
      if (e_pop) begin
        void'(q_pc.pop_front());
        void'(q_instr.pop_front());
      end
      if (e_fetch) begin
        q_pc.push_back(m_pc);
        q_instr.push_back(imem_data);
        if (cur_inj) m_halted = 1'b1;
        else         m_pc     = m_pc + 16'd2;
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc(input logic rdy, input logic redir, input logic [15:0] rpc,
                     input logic inj);
    drive(rdy, redir, rpc, inj);
    advance();
  endtask

  task automatic test_reset();
    // rst_n has been low across a clock edge
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (imem_rd !== 1'b0) begin bad++; $display("FAIL reset_rd got=%b exp=0", imem_rd); end
    total++; if (fetch_pc !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h exp=0000", fetch_pc); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 16'h0, 1'b0);
      if (i >= 1) begin
        total++; if (out_pc !== 16'(2 * (i - 1))) begin bad++;
          $display("FAIL stream_pc got=%h exp=%h", out_pc, 16'(2 * (i - 1))); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL stream_count got=%0d exp=1", count); end
      end
      advance();
    end
  endtask

  task automatic test_fill();
    cyc(1'b0, 1'b1, 16'h0000, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", count); end
    total++; if (imem_rd !== 1'b0) begin bad++; $display("FAIL fill_rd got=%b exp=0", imem_rd); end
    total++; if (fetch_pc !== 16'h0008) begin bad++; $display("FAIL fill_pc got=%h exp=0008", fetch_pc); end
    advance();
  endtask

  task automatic test_full_pop();
    // queue is full from test_fill; pop and fetch every cycle
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 16'h0, 1'b0);
      total++; if (imem_rd !== 1'b1) begin bad++; $display("FAIL fullpop_rd got=%b exp=1", imem_rd); end
      total++; if (count !== 3'd4) begin bad++; $display("FAIL fullpop_count got=%0d exp=4", count); end
      total++; if (out_pc !== 16'(2 * i)) begin bad++;
        $display("FAIL fullpop_pc got=%h exp=%h", out_pc, 16'(2 * i)); end
      advance();
    end
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_redirect();
    cyc(1'b0, 1'b1, 16'h0010, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b1, 1'b1, 16'h0040, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b exp=0", out_valid); end
    advance();
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    total++; if (count !== 3'd0) begin bad++; $display("FAIL redir_count got=%0d exp=0", count); end
    advance();
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    total++; if (out_pc !== 16'h0040 || out_valid !== 1'b1) begin bad++;
      $display("FAIL redir_head got=%h/%b exp=0040/1", out_pc, out_valid); end
    advance();
  endtask

  task automatic test_halt();
    cyc(1'b0, 1'b1, 16'h0000, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 16'h0, m_pc == 16'h0006);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", halted); end
    total++; if (imem_rd !== 1'b0) begin bad++; $display("FAIL halt_rd got=%b exp=0", imem_rd); end
    total++; if (fetch_pc !== 16'h0006) begin bad++; $display("FAIL halt_pc got=%h exp=0006", fetch_pc); end
    advance();
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 16'h0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    total++; if (count !== 3'd0 || fetch_pc !== 16'h0006) begin bad++;
      $display("FAIL halt_drain got=%0d/%h exp=0/0006", count, fetch_pc); end
    advance();
    cyc(1'b1, 1'b1, 16'h0020, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    total++; if (halted !== 1'b0 || imem_addr !== 16'h0020) begin bad++;
      $display("FAIL halt_restart got=%b/%h exp=0/0020", halted, imem_addr); end
    advance();
    // halt opcode presented together with redirect: redirect wins
    cyc(1'b1, 1'b1, 16'h0030, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_wrap();
    cyc(1'b1, 1'b1, 16'hFFFC, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_async_reset();
    cyc(1'b0, 1'b1, 16'h0100, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL areset_count got=%0d exp=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
    total++; if (fetch_pc !== 16'h0000) begin bad++; $display("FAIL areset_pc got=%h exp=0000", fetch_pc); end
    total++; if (imem_rd !== 1'b0) begin bad++; $display("FAIL areset_rd got=%b exp=0", imem_rd); end
    model_reset();
    rst_n = 1'b1;
    test_streaming();
  endtask

  task automatic test_random();
    logic        rdy, redir, inj;
    logic [15:0] rpc;
    for (int i = 0; i < 400; i++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0);
      inj   = ($urandom_range(0, 9) == 0);
      rpc   = 16'($urandom) & 16'hFFFE;
      cyc(rdy, redir, rpc, inj);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    out_ready   = 1'b0;
    imem_data   = 16'h0;
    cur_inj     = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_streaming();
    test_fill();
    test_full_pop();
    test_redirect();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
